// File: rtl/booth_iter_mul_ctrl.sv
// Radix-4 Booth 32x32->64 iterative multiplier sequencer.
// Feeds one Booth window per cycle to an external PP generator and accumulates.
module booth_iter_mul_ctrl #(
    parameter int STEPS = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_signed,
    input  logic        b_signed,
    input  logic        flush,
    output logic [2:0]  pp_src,
    output logic [63:0] pp_x,
    input  logic [63:0] pp_p,
    input  logic        pp_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [34:0] mplier;
    logic        accept;
    logic        last;
    logic [63:0] a_ext;
    logic [33:0] b_ext;

    assign accept = (state == IDLE) && in_valid && !flush;
    assign last   = (cnt == 5'(STEPS - 1));
    assign a_ext  = a_signed ? {{32{a[31]}}, a} : {32'b0, a};
    assign b_ext  = b_signed ? {{2{b[31]}}, b} : {2'b00, b};

    // State register; async reset returns straight to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins in every state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: if (flush || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, Booth stepping and accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= a_ext;
            mplier <= {b_ext, 1'b0};
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc + pp_p + {63'b0, pp_c};
            mcand  <= mcand << 2;
            mplier <= mplier >> 2;
            cnt    <= cnt + 5'd1;
        end
    end

    // Generator sees a zero window outside BUSY so it contributes nothing.
    always_comb begin
        pp_src = 3'b000;
        pp_x   = '0;
        if (state == BUSY) begin
            pp_src = mplier[2:0];
            pp_x   = mcand;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = acc;

endmodule
